// File: rtl/day1_pkg.sv
// Shared types and ASCII constants for the day-1 puzzle front end.
package day1_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_DIR  = 3'd1,
        S_NUM  = 3'd2,
        S_SKIP = 3'd3,
        S_EMIT = 3'd4,
        S_DONE = 3'd5
    } parse_state_t;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/day1_dec_accum.sv
// Saturating decimal accumulator; value is the post-update result so the
// parser can capture it on the same edge that consumes the final digit.
module day1_dec_accum
    import day1_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic             sat,
    output logic             has_digit
);

    logic [WIDTH-1:0] acc_r;
    logic             has_digit_r;
    logic [WIDTH+3:0] wide_s;
    logic             ovf_s;

    assign wide_s    = ({4'd0, acc_r} << 3) + ({4'd0, acc_r} << 1) + {{WIDTH{1'b0}}, digit};
    assign ovf_s     = |wide_s[WIDTH+3:WIDTH];
    assign has_digit = has_digit_r;

    // Next accumulator value and overflow flag for the current digit
    always_comb begin
        value = acc_r;
        sat   = 1'b0;
        if (clear) begin
            value = {WIDTH{1'b0}};
        end else if (digit_en) begin
            sat   = ovf_s;
            value = ovf_s ? {WIDTH{1'b1}} : wide_s[WIDTH-1:0];
        end else begin
            value = acc_r;
        end
    end

    // Accumulator and has-digit registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r       <= {WIDTH{1'b0}};
            has_digit_r <= 1'b0;
        end else begin
            acc_r <= value;
            if (clear) begin
                has_digit_r <= 1'b0;
            end else begin
                has_digit_r <= has_digit_r | digit_en;
            end
        end
    end

endmodule

// File: rtl/day1_line_parser.sv
// Turns an ASCII byte stream of "L68"/"R48" lines into the day1_puzzle
// init/valid/rotation/rotate_amount command stream.
module day1_line_parser
    import day1_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int START_POS = 50,
    parameter int DIAL_MAX  = 99
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             init,
    output logic             valid,
    input  logic             ready,
    output logic             rotation,
    output logic [WIDTH-1:0] rotate_amount,
    output logic [WIDTH-1:0] max_number,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] cmd_count
);

    parse_state_t     state_r, state_next_s;
    logic             started_r, end_r;
    logic             in_ready_r, init_r, valid_r, rotation_r, done_r, error_r;
    logic [WIDTH-1:0] rotate_amount_r, cmd_count_r;

    logic             accept_s, cmd_accept_s, is_dir_s;
    logic             rot_load_s, acc_clear_s, digit_en_s, error_set_s;
    logic [WIDTH-1:0] acc_value_s;
    logic             acc_sat_s, acc_has_digit_s;

    assign accept_s     = in_valid && in_ready_r;
    assign cmd_accept_s = valid_r && ready;
    assign is_dir_s     = (in_data == ASCII_L) || (in_data == ASCII_R);

    day1_dec_accum #(.WIDTH(WIDTH)) u_accum (
        .clock     (clock),
        .reset     (reset),
        .clear     (acc_clear_s),
        .digit_en  (digit_en_s),
        .digit     (in_data[3:0]),
        .value     (acc_value_s),
        .sat       (acc_sat_s),
        .has_digit (acc_has_digit_s)
    );

    // Next-state and per-byte actions; in_last always forces the end path
    always_comb begin
        state_next_s = state_r;
        rot_load_s   = 1'b0;
        acc_clear_s  = 1'b0;
        digit_en_s   = 1'b0;
        error_set_s  = 1'b0;
        case (state_r)
            S_INIT: begin
                // Hold one extra edge after reset so init lands as a registered pulse
                if (started_r) state_next_s = S_DIR;
                else           state_next_s = S_INIT;
            end
            S_DIR: begin
                if (!accept_s) begin
                    state_next_s = S_DIR;
                end else if (is_dir_s) begin
                    rot_load_s   = 1'b1;
                    acc_clear_s  = 1'b1;
                    state_next_s = in_last ? S_DONE : S_NUM;
                end else if (is_eol(in_data) || (in_data == ASCII_SP)) begin
                    state_next_s = in_last ? S_DONE : S_DIR;
                end else begin
                    error_set_s  = 1'b1;
                    state_next_s = in_last ? S_DONE : S_SKIP;
                end
            end
            S_NUM: begin
                if (!accept_s) begin
                    state_next_s = S_NUM;
                end else if (is_digit(in_data)) begin
                    digit_en_s   = 1'b1;
                    state_next_s = in_last ? S_EMIT : S_NUM;
                end else if (is_eol(in_data)) begin
                    if (acc_has_digit_s) begin
                        state_next_s = S_EMIT;
                    end else begin
                        error_set_s  = 1'b1;
                        state_next_s = in_last ? S_DONE : S_DIR;
                    end
                end else begin
                    error_set_s  = 1'b1;
                    state_next_s = in_last ? S_DONE : S_SKIP;
                end
            end
            S_SKIP: begin
                if (!accept_s)                  state_next_s = S_SKIP;
                else if (in_last)               state_next_s = S_DONE;
                else if (in_data == ASCII_LF)   state_next_s = S_DIR;
                else                            state_next_s = S_SKIP;
            end
            S_EMIT: begin
                if (cmd_accept_s) state_next_s = end_r ? S_DONE : S_DIR;
                else              state_next_s = S_EMIT;
            end
            S_DONE:  state_next_s = S_DONE;
            default: state_next_s = S_INIT;
        endcase
    end

    // State plus registered outputs decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= S_INIT;
            started_r       <= 1'b0;
            end_r           <= 1'b0;
            in_ready_r      <= 1'b0;
            init_r          <= 1'b0;
            valid_r         <= 1'b0;
            rotation_r      <= 1'b0;
            rotate_amount_r <= {WIDTH{1'b0}};
            done_r          <= 1'b0;
            error_r         <= 1'b0;
            cmd_count_r     <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            started_r  <= 1'b1;
            end_r      <= end_r | (accept_s && in_last);
            in_ready_r <= (state_next_s == S_DIR) || (state_next_s == S_NUM) ||
                          (state_next_s == S_SKIP);
            init_r     <= (state_next_s == S_INIT);
            valid_r    <= (state_next_s == S_EMIT);
            done_r     <= (state_next_s == S_DONE);
            error_r    <= error_r | error_set_s | acc_sat_s;
            if (rot_load_s) begin
                rotation_r <= (in_data == ASCII_R);
            end else begin
                rotation_r <= rotation_r;
            end
            if (state_next_s == S_INIT) begin
                rotate_amount_r <= WIDTH'(START_POS);
            end else if ((state_next_s == S_EMIT) && (state_r != S_EMIT)) begin
                rotate_amount_r <= acc_value_s;
            end else begin
                rotate_amount_r <= rotate_amount_r;
            end
            if (cmd_accept_s) begin
                cmd_count_r <= cmd_count_r + WIDTH'(1'b1);
            end else begin
                cmd_count_r <= cmd_count_r;
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign init          = init_r;
    assign valid         = valid_r;
    assign rotation      = rotation_r;
    assign rotate_amount = rotate_amount_r;
    assign max_number    = WIDTH'(DIAL_MAX);
    assign done          = done_r;
    assign error         = error_r;
    assign cmd_count     = cmd_count_r;

endmodule

// File: tb/tb_day1_line_parser.sv
// Bench for day1_line_parser: directed cases plus random byte streams checked
// against a software-style line scanner.
module tb_day1_line_parser;

    typedef struct packed {
        logic        rot;
        logic [15:0] amt;
    } cmd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        ready = 1'b0;
    logic        in_ready, init, valid, rotation, done, error;
    logic [15:0] rotate_amount, max_number, cmd_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stream_q[$];
    cmd_t        exp_q[$];
    cmd_t        got_q[$];
    cmd_t        e_c;
    bit          chk_en = 1'b0;
    bit          ready_rand = 1'b0;
    logic        ready_val = 1'b0;
    int          acc_seen = 0;
    bit          hold_r = 1'b0;
    logic        hold_rot;
    logic [15:0] hold_amt;
    bit          m_err;
    int          n_exp;

    day1_line_parser #(.WIDTH(16), .START_POS(50), .DIAL_MAX(99)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .init(init), .valid(valid),
        .ready(ready), .rotation(rotation), .rotate_amount(rotate_amount),
        .max_number(max_number), .done(done), .error(error), .cmd_count(cmd_count)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(posedge clock) begin
        #1;
        ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_val;
    end

    // Every-cycle compare against the expected command queue and handshake rules
    always @(negedge clock) begin
        if (reset) begin
            acc_seen = 0;
            hold_r   = 1'b0;
        end else if (chk_en) begin
            check("max_number", 32'(max_number), 32'd99);
            check("cmd_count", 32'(cmd_count), 32'(acc_seen));
            if (init) check("init_amount", 32'(rotate_amount), 32'd50);
            if (valid) begin
                check("valid_vs_in_ready", 32'(in_ready), 32'd0);
                if (hold_r) begin
                    check("hold_rotation", 32'(rotation), 32'(hold_rot));
                    check("hold_amount", 32'(rotate_amount), 32'(hold_amt));
                end
                if (ready) begin
                    got_q.push_back({rotation, rotate_amount});
                    acc_seen++;
                    hold_r = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cmd: got rot=%0d amt=%0d expected none", rotation, rotate_amount);
                    end else begin
                        e_c = exp_q.pop_front();
                        check("cmd_rotation", 32'(rotation), 32'(e_c.rot));
                        check("cmd_amount", 32'(rotate_amount), 32'(e_c.amt));
                    end
                end else begin
                    hold_r   = 1'b1;
                    hold_rot = rotation;
                    hold_amt = rotate_amount;
                end
            end else begin
                if (hold_r) check("valid_dropped", 32'(valid), 32'd1);
                hold_r = 1'b0;
            end
        end
    end

    // Reference: scan the stream like a text parser and list the commands it yields
    function automatic void model(output bit err);
        int i, n, v, nd;
        logic r;
        logic [7:0] c;
        i = 0;
        n = stream_q.size();
        err = 1'b0;
        while (i < n) begin
            c = stream_q[i];
            if (c == 8'h0A || c == 8'h0D || c == 8'h20) begin
                i++;
            end else if (c == 8'h4C || c == 8'h52) begin
                r = (c == 8'h52);
                v = 0;
                nd = 0;
                i++;
                while (i < n && stream_q[i] >= 8'h30 && stream_q[i] <= 8'h39) begin
                    v = v * 10 + int'(stream_q[i]) - 48;
                    if (v > 65535) begin
                        v = 65535;
                        err = 1'b1;
                    end
                    nd++;
                    i++;
                end
                if (i == n) begin
                    if (nd > 0) exp_q.push_back({r, 16'(v)});
                end else if (stream_q[i] == 8'h0A || stream_q[i] == 8'h0D) begin
                    if (nd > 0) exp_q.push_back({r, 16'(v)});
                    else err = 1'b1;
                    i++;
                end else begin
                    err = 1'b1;
                    while (i < n && stream_q[i] != 8'h0A) i++;
                    i++;
                end
            end else begin
                err = 1'b1;
                while (i < n && stream_q[i] != 8'h0A) i++;
                i++;
            end
        end
    endfunction

    function automatic void load(input string s);
        stream_q.delete();
        for (int k = 0; k < s.len(); k++) stream_q.push_back(s[k]);
    endfunction

    function automatic void add_digits(input int n);
        for (int k = 0; k < n; k++) stream_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
    endfunction

    function automatic void gen();
        int nl, kind;
        logic [7:0] d;
        stream_q.delete();
        nl = $urandom_range(1, 6);
        for (int l = 0; l < nl; l++) begin
            kind = $urandom_range(0, 9);
            d = ($urandom_range(0, 1) != 0) ? 8'h52 : 8'h4C;
            case (kind)
                0, 1, 2, 3, 4: begin
                    stream_q.push_back(d);
                    add_digits($urandom_range(1, 5));
                    if ($urandom_range(0, 1) != 0) stream_q.push_back(8'h0D);
                    stream_q.push_back(8'h0A);
                end
                5: begin
                    stream_q.push_back(8'h20);
                    stream_q.push_back(8'h0A);
                end
                6: begin
                    stream_q.push_back(($urandom_range(0, 1) != 0) ? 8'h58 : 8'h37);
                    add_digits(2);
                    stream_q.push_back(8'h0A);
                end
                7: begin
                    stream_q.push_back(d);
                    stream_q.push_back(8'h0A);
                end
                8: begin
                    stream_q.push_back(d);
                    add_digits(1);
                    stream_q.push_back(8'h78);
                    add_digits(1);
                    stream_q.push_back(8'h0A);
                end
                default: begin
                    stream_q.push_back(d);
                    add_digits(2);
                    stream_q.push_back(8'h0D);
                end
            endcase
        end
        if ($urandom_range(0, 1) != 0 && stream_q[$] == 8'h0A) void'(stream_q.pop_back());
    endfunction

    task automatic send_stream(input bit with_last, input int gap_max);
        bit got;
        for (int k = 0; k < stream_q.size(); k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_data  = stream_q[k];
            in_last  = with_last && (k == stream_q.size() - 1);
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clock);
                if (in_ready) got = 1'b1;
            end
            check("byte_accept_timeout", 32'(got), 32'd1);
            if (got) begin
                @(posedge clock);
                #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!got) return;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("done_reached", 32'(seen), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("done_valid", 32'(valid), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        chk_en   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        got_q.delete();
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_init", 32'(init), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_rotation", 32'(rotation), 32'd0);
        check("rst_amount", 32'(rotate_amount), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_max_number", 32'(max_number), 32'd99);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clock);
        #1;
        check("init_pulse", 32'(init), 32'd1);
        check("init_amount_lit", 32'(rotate_amount), 32'd50);
        check("init_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        check("init_cleared", 32'(init), 32'd0);
        check("in_ready_after_init", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two well-formed lines, puzzle always ready
        do_reset();
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        load("L68\nR48\n");
        model(m_err);
        check("model_l68_n", 32'(exp_q.size()), 32'd2);
        check("model_l68_amt0", 32'(exp_q[0].amt), 32'd68);
        check("model_r48_rot1", 32'(exp_q[1].rot), 32'd1);
        send_stream(1'b1, 0);
        wait_done();
        check("l68_count", 32'(cmd_count), 32'd2);
        check("l68_error", 32'(error), 32'd0);
        check("l68_got_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("l68_rot", 32'(got_q[0].rot), 32'd0);
            check("l68_amt", 32'(got_q[0].amt), 32'd68);
            check("r48_rot", 32'(got_q[1].rot), 32'd1);
            check("r48_amt", 32'(got_q[1].amt), 32'd48);
        end

        // Back-pressure: command held for 7 cycles
        do_reset();
        ready_val = 1'b0;
        load("R5\n");
        model(m_err);
        send_stream(1'b1, 0);
        for (int c = 0; c < 7; c++) begin
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_amount", 32'(rotate_amount), 32'd5);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        ready_val = 1'b1;
        wait_done();
        check("bp_got_n", 32'(got_q.size()), 32'd1);
        check("bp_count", 32'(cmd_count), 32'd1);

        // Malformed first line is skipped
        do_reset();
        load("X12\nL3\n");
        model(m_err);
        check("model_x12_err", 32'(m_err), 32'd1);
        check("model_x12_n", 32'(exp_q.size()), 32'd1);
        send_stream(1'b1, 1);
        wait_done();
        check("x12_error", 32'(error), 32'd1);
        check("x12_count", 32'(cmd_count), 32'd1);
        if (got_q.size() == 1) check("x12_amt", 32'(got_q[0].amt), 32'd3);

        // Overflow saturates
        do_reset();
        load("R99999\n");
        model(m_err);
        check("model_sat_amt", 32'(exp_q[0].amt), 32'd65535);
        send_stream(1'b1, 0);
        wait_done();
        check("sat_error", 32'(error), 32'd1);
        if (got_q.size() == 1) check("sat_amt", 32'(got_q[0].amt), 32'd65535);
        else check("sat_got_n", 32'(got_q.size()), 32'd1);

        // Unterminated final line
        do_reset();
        load("L7");
        model(m_err);
        send_stream(1'b1, 0);
        wait_done();
        check("l7_count", 32'(cmd_count), 32'd1);
        check("l7_done", 32'(done), 32'd1);
        if (got_q.size() == 1) check("l7_amt", 32'(got_q[0].amt), 32'd7);
        else check("l7_got_n", 32'(got_q.size()), 32'd1);

        // Reset in the middle of a line
        do_reset();
        load("R4");
        send_stream(1'b0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("midrst_no_valid", 32'(valid), 32'd0);
        check("midrst_got_n", 32'(got_q.size()), 32'd0);
        do_reset();
        load("L1\n");
        model(m_err);
        send_stream(1'b1, 0);
        wait_done();
        check("midrst_after_count", 32'(cmd_count), 32'd1);

        // Random streams with gaps and random back-pressure
        for (int t = 0; t < 40; t++) begin
            do_reset();
            ready_rand = 1'b1;
            gen();
            model(m_err);
            n_exp = exp_q.size();
            send_stream(1'b1, 3);
            wait_done();
            check("rnd_count", 32'(cmd_count), 32'(n_exp));
            check("rnd_error", 32'(error), 32'(m_err));
            check("rnd_left", 32'(exp_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/day1_line_parser.md
# day1_line_parser

Hardware front end for `day1_puzzle`: consumes the raw ASCII puzzle input as a byte stream (lines such as `L68`, `R48`) and produces the `init` / `valid` / `rotation` / `rotate_amount` / `max_number` command stream that `day1_puzzle` accepts. It replaces the file-reading stimulus with synthesizable logic, so the full day-1 pipeline runs on the FPGA from a UART or BRAM byte source. Its command-side ports connect straight onto `day1_puzzle` ports of the same name.

## Interface
- `WIDTH`, 16, width of `rotate_amount`, `max_number` and `cmd_count`.
- `START_POS`, 50, dial start position sent with `init`.
- `DIAL_MAX`, 99, highest dial value, driven on `max_number`.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  byte source has `in_data`.
- `in_data`  in  8  ASCII byte.
- `in_last`  in  1  qualifies the final byte of the input.
- `in_ready`  out  1  parser accepts a byte this cycle.
- `init`  out  1  one-cycle start pulse to the puzzle.
- `valid`  out  1  command valid.
- `ready`  in  1  puzzle accepts a command.
- `rotation`  out  1  1 = `R`, 0 = `L`.
- `rotate_amount`  out  WIDTH  distance, or `START_POS` while `init` is high.
- `max_number`  out  WIDTH  constant `DIAL_MAX`.
- `done`  out  1  sticky; input exhausted and last command accepted.
- `error`  out  1  sticky; malformed line or overflow seen.
- `cmd_count`  out  WIDTH  commands accepted by the puzzle; wraps at 2^WIDTH.

## Operation
- **States:** `S_INIT` → `S_DIR` → `S_NUM` → `S_EMIT` → `S_DIR` … → `S_DONE`. Extra state `S_SKIP` discards bytes until end of line.
- **S_INIT**
  - Entered the first cycle after reset deasserts.
  - Drives `init=1` and `rotate_amount=START_POS` for exactly one cycle, then goes to `S_DIR`.
  - Does not wait for `ready`.
- **S_DIR**
  - `in_ready=1`.
  - `L` or `R`: latch `rotation`, clear the accumulator, go to `S_NUM`.
  - CR, LF, space: ignored.
  - Any other byte: set `error`, go to `S_SKIP`.
- **S_NUM**
  - `in_ready=1`.
  - Digit: `acc = acc*10 + (byte-0x30)`, computed at WIDTH+4 bits. A result above 2^WIDTH-1 saturates to 2^WIDTH-1 and sets `error`.
  - LF or CR after at least one digit: go to `S_EMIT`.
  - LF or CR with no digit: set `error`, go to `S_DIR`.
  - Any other byte: set `error`, go to `S_SKIP`.
- **S_SKIP**
  - `in_ready=1`.
  - Drops bytes until LF, then goes to `S_DIR`.
- **S_EMIT**
  - `in_ready=0`, `valid=1`, `rotate_amount=acc`.
  - Holds until `valid && ready` at a rising edge, then increments `cmd_count`.
  - Goes to `S_DONE` if the end flag is set, otherwise to `S_DIR`.
- **in_last handling** (only when `in_valid` is high):
  - The accepted byte is processed normally and the end flag is set.
  - If that byte completes a line, or is a digit ending an unterminated line with at least one digit, the command goes to `S_EMIT` and then `S_DONE`.
  - Otherwise go straight to `S_DONE`.
- **S_DONE**: `done=1`, `in_ready=0`; terminal until reset.
- **Reset mid-operation**: abandons any partial line and any pending command; `init` is reissued after release.

## Timing
- **Reset values:** `in_ready=0`, `init=0`, `valid=0`, `rotation=0`, `rotate_amount=0`, `done=0`, `error=0`, `cmd_count=0`. `max_number=DIAL_MAX` at all times.
- All outputs are registered.
- **Byte handshake:** a byte is consumed at an edge where `in_valid && in_ready`. The sustained rate while parsing is one byte per cycle.
- **Command latency:** terminating byte accepted at edge N → `valid` high during cycle N+1.
  - If `ready=1` at edge N+1, `valid` drops and `in_ready` rises in cycle N+2.
  - Once asserted, `valid`, `rotation` and `rotate_amount` stay stable until accepted.
- **Back-pressure:**
  - `ready=0` holds `S_EMIT` indefinitely.
  - `in_valid=0` stalls parsing without changing state.

## Structure
- **Package `day1_pkg`:**
  - state enum `parse_state_t`;
  - ASCII constants `ASCII_L`, `ASCII_R`, `ASCII_0`, `ASCII_9`, `ASCII_LF`, `ASCII_CR`, `ASCII_SP`.
- **Sub-module `day1_dec_accum`**: parameter `WIDTH`; inputs clear, digit-enable and a 4-bit digit; outputs the accumulated value, a saturation flag and a has-digit flag.
- The FSM, handshake and counters stay in `day1_line_parser`.

## Test plan
- **Reset release:** `init` high for one cycle with `rotate_amount=50` and `max_number=99`; all other outputs at reset values; `in_ready=1` the next cycle.
- **Stream `L68\nR48\n` with `ready=1`:**
  - first command `rotation=0`, `rotate_amount=68`, `valid` high for one cycle;
  - second command `rotation=1`, `rotate_amount=48`;
  - `cmd_count=2`; `error=0`.
- **`R5\n` with `ready=0` for 7 cycles:** `valid` held with `rotate_amount=5` for all 7 cycles; `in_ready=0` throughout; exactly one acceptance when `ready` rises.
- **`X12\nL3\n`:** `error=1`; only `L3` is emitted; `cmd_count=1`.
- **`R99999\n` with WIDTH=16:** `rotate_amount=65535` and `error=1`.
- **Unterminated `L7`, `in_last` on `7`:** one command with `rotate_amount=7`; `done=1` after acceptance; `in_ready` stays 0.
- **Reset asserted mid-line during `R4`:** no command emitted; after release, `init` pulses again.
